// File: rtl/dcache_ctrl.sv
// Set-associative write-through data cache with miss FSM and saturating hit/miss counters.
// One word per line, no-write-allocate; loads hit with zero latency.
module dcache_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SETS       = 8,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt
);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W - 2;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] RESP = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]            state;
    logic [2:0]            stateNext;
    logic [WAYS-1:0]       validQ [SETS];
    logic [WAY_W-1:0]      ptrQ   [SETS];
    logic [TAG_W-1:0]      tagQ   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] dataQ  [SETS][WAYS];
    logic [DATA_WIDTH-1:0] fillQ;

    logic [IDX_W-1:0]      reqIdx;
    logic [TAG_W-1:0]      reqTag;
    logic                  hit;
    logic [WAY_W-1:0]      hitWay;
    logic [DATA_WIDTH-1:0] hitData;
    logic                  anyInvalid;
    logic [WAY_W-1:0]      victim;
    logic                  fillEn;
    logic                  wrUpd;
    logic                  hitInc;
    logic                  missInc;
    logic                  unusedAddrBits;

    assign reqIdx         = cpu_addr[IDX_W+1:2];
    assign reqTag         = cpu_addr[ADDR_WIDTH-1:IDX_W+2];
    assign unusedAddrBits = ^cpu_addr[1:0];

    // cpu_addr/cpu_wdata are held by the pipeline while stalled, so these stay stable until mem_ack
    assign mem_addr  = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
    assign mem_wdata = cpu_wdata;

    // Tag match across the indexed set
    always_comb begin
        hit     = 1'b0;
        hitWay  = '0;
        hitData = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (validQ[reqIdx][w] && (tagQ[reqIdx][w] == reqTag)) begin
                hit     = 1'b1;
                hitWay  = WAY_W'(w);
                hitData = dataQ[reqIdx][w];
            end
        end
    end

    // Victim: lowest-index invalid way, else the round-robin pointer
    always_comb begin
        anyInvalid = 1'b0;
        victim     = ptrQ[reqIdx];
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!validQ[reqIdx][w]) begin
                anyInvalid = 1'b1;
                victim     = WAY_W'(w);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        fillEn    = 1'b0;
        wrUpd     = 1'b0;
        hitInc    = 1'b0;
        missInc   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        cpu_stall = 1'b1;
                        stateNext = WR;
                    end else if (hit) begin
                        cpu_rdata = hitData;
                        hitInc    = 1'b1;
                    end else begin
                        cpu_stall = 1'b1;
                        missInc   = 1'b1;
                        stateNext = RD;
                    end
                end
            end
            RD: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                if (mem_ack) begin
                    fillEn    = 1'b1;
                    stateNext = RESP;
                end
            end
            RESP: begin
                cpu_rdata = fillQ;
                stateNext = IDLE;
            end
            WR: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                if (mem_ack) begin
                    wrUpd     = hit;
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Valid bits, replacement pointers, fill register and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < int'(SETS); s++) begin
                validQ[s] <= '0;
                ptrQ[s]   <= '0;
            end
            fillQ    <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (fillEn) begin
                validQ[reqIdx][victim] <= 1'b1;
                fillQ                  <= mem_rdata;
                if (!anyInvalid) begin
                    ptrQ[reqIdx] <= (ptrQ[reqIdx] == WAY_W'(WAYS - 1)) ? '0 : ptrQ[reqIdx] + WAY_W'(1);
                end
            end
            if (hitInc && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + CNT_WIDTH'(1);
            end
            if (missInc && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Tag and data arrays carry no reset; validity is tracked separately
    always_ff @(posedge clk) begin
        if (fillEn && !rst) begin
            tagQ[reqIdx][victim]  <= reqTag;
            dataQ[reqIdx][victim] <= mem_rdata;
        end else if (wrUpd && !rst) begin
            dataQ[reqIdx][hitWay] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: miss/hit timing, replacement, write-through, reset abort, saturation.
module tb_dcache_ctrl;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;

    int testCount = 0;
    int failCount = 0;

    logic autoAck = 1'b1;
    logic forceAck = 1'b0;
    int   ackDelay = 3;
    int   waitCnt = 0;
    logic [DW-1:0] memArr [1024];
    logic [1023:0] wrote = '0;

    dcache_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SETS(8), .WAYS(2), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] defaultWord(input int idx);
        if (idx == 64) return 32'hDEADBEEF;
        return 32'hC0DE0000 + 32'(idx);
    endfunction

    // Backing memory: acks after ackDelay request cycles
    always @(negedge clk) begin
        int idx;
        idx = int'(mem_addr[11:2]);
        if (forceAck) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hBAD0BAD0;
        end else if (autoAck && mem_req && (waitCnt == ackDelay)) begin
            mem_ack = 1'b1;
            waitCnt = 0;
            if (mem_we) begin
                memArr[idx] = mem_wdata;
                wrote[idx]  = 1'b1;
            end else begin
                mem_rdata = wrote[idx] ? memArr[idx] : defaultWord(idx);
            end
        end else begin
            mem_ack = 1'b0;
            if (autoAck && mem_req) waitCnt++;
            else waitCnt = 0;
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic doLoad(input logic [31:0] addr, input logic [31:0] expData,
                          input logic expMiss, input string tag, output int cycles);
        logic sawReq;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
        #1;
        cycles = 0;
        sawReq = 1'b0;
        while (cpu_stall && cycles < 50) begin
            if (mem_req) begin
                sawReq = 1'b1;
                checkVal({tag, "_maddr"}, mem_addr, {addr[31:2], 2'b00});
                checkVal({tag, "_mwe"}, 32'(mem_we), 32'd0);
            end
            cycles++;
            @(negedge clk);
            #1;
        end
        checkVal({tag, "_notimeout"}, 32'(cycles < 50), 32'd1);
        checkVal({tag, "_rdata"}, cpu_rdata, expData);
        checkVal({tag, "_memreq"}, 32'(sawReq), 32'(expMiss));
        @(negedge clk);
        cpu_req = 1'b0;
    endtask

    task automatic doStore(input logic [31:0] addr, input logic [31:0] data, input string tag);
        int cycles;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = addr; cpu_wdata = data;
        #1;
        cycles = 0;
        while (cpu_stall && cycles < 50) begin
            if (mem_req) begin
                checkVal({tag, "_mwe"}, 32'(mem_we), 32'd1);
                checkVal({tag, "_mwdata"}, mem_wdata, data);
                checkVal({tag, "_maddr"}, mem_addr, {addr[31:2], 2'b00});
            end
            cycles++;
            @(negedge clk);
            #1;
        end
        checkVal({tag, "_stallcyc"}, 32'(cycles), 32'd5);
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        doReset();
        checkVal("rst_hit", 32'(hit_cnt), 32'd0);
        checkVal("rst_miss", 32'(miss_cnt), 32'd0);
        checkVal("rst_memreq", 32'(mem_req), 32'd0);
        checkVal("rst_memwe", 32'(mem_we), 32'd0);
        checkVal("rst_stall", 32'(cpu_stall), 32'd0);
        checkVal("rst_rdata", cpu_rdata, 32'd0);

        // Cold miss then hit
        doLoad(32'h100, 32'hDEADBEEF, 1'b1, "t1_miss", c);
        checkVal("t1_stallcyc", 32'(c), 32'd5);
        checkVal("t1_misscnt", 32'(miss_cnt), 32'd1);
        checkVal("t1_hitcnt0", 32'(hit_cnt), 32'd0);
        doLoad(32'h100, 32'hDEADBEEF, 1'b0, "t1_hit", c);
        checkVal("t1_hitstall", 32'(c), 32'd0);
        checkVal("t1_hitcnt", 32'(hit_cnt), 32'd1);

        // Replacement within set 0
        doReset();
        doLoad(32'h000, 32'hC0DE0000, 1'b1, "t2_a", c);
        doLoad(32'h020, 32'hC0DE0008, 1'b1, "t2_b", c);
        doLoad(32'h040, 32'hC0DE0010, 1'b1, "t2_c", c);
        doLoad(32'h020, 32'hC0DE0008, 1'b0, "t2_bhit", c);
        doLoad(32'h000, 32'hC0DE0000, 1'b1, "t2_aevict", c);
        checkVal("t2_misscnt", 32'(miss_cnt), 32'd4);
        checkVal("t2_hitcnt", 32'(hit_cnt), 32'd1);

        // Store hit updates cached copy
        doLoad(32'h100, 32'hDEADBEEF, 1'b1, "t3_fill", c);
        doStore(32'h100, 32'h55, "t3_st");
        doLoad(32'h100, 32'h55, 1'b0, "t3_hit", c);
        checkVal("t3_hitcnt", 32'(hit_cnt), 32'd2);
        checkVal("t3_misscnt", 32'(miss_cnt), 32'd5);

        // Store miss does not allocate
        doStore(32'h200, 32'h77, "t4_st");
        checkVal("t4_cnt_untouched", 32'(miss_cnt), 32'd5);
        doLoad(32'h100, 32'h55, 1'b0, "t4_keep", c);
        doLoad(32'h200, 32'h77, 1'b1, "t4_miss", c);
        checkVal("t4_misscnt", 32'(miss_cnt), 32'd6);
        checkVal("t4_hitcnt", 32'(hit_cnt), 32'd3);

        // Reset while a refill is outstanding, then a late ack
        autoAck = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkVal("t5_inflight", 32'(mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkVal("t5_reqdrop", 32'(mem_req), 32'd0);
        checkVal("t5_stall", 32'(cpu_stall), 32'd0);
        checkVal("t5_hitcnt", 32'(hit_cnt), 32'd0);
        checkVal("t5_misscnt", 32'(miss_cnt), 32'd0);
        @(posedge clk);
        forceAck = 1'b1;
        @(posedge clk);
        forceAck = 1'b0;
        @(negedge clk);
        #1;
        checkVal("t5_lateack_req", 32'(mem_req), 32'd0);
        autoAck = 1'b1;
        doLoad(32'h300, 32'hC0DE00C0, 1'b1, "t5_reload", c);
        checkVal("t5_misscnt2", 32'(miss_cnt), 32'd1);

        // Hit counter saturation
        for (int i = 0; i < 20; i++) begin
            doLoad(32'h300, 32'hC0DE00C0, 1'b0, "t6_hit", c);
        end
        checkVal("t6_hitsat", 32'(hit_cnt), 32'd15);
        checkVal("t6_misscnt", 32'(miss_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
